// File: rtl/food_ctrl.sv
// Food-placement controller: samples candidate points, checks them against the snake body,
// then holds the accepted food square and drives a registered per-pixel food flag.
module food_ctrl #(
  parameter int FOOD_SIZE = 10,
  parameter int MAX_RETRY = 8
) (
  input  logic       clk_vga,
  input  logic       rst,
  input  logic [9:0] rand_x,
  input  logic [9:0] rand_y,
  input  logic       eat,
  output logic       chk_req,
  output logic [9:0] chk_x,
  output logic [9:0] chk_y,
  input  logic       chk_ack,
  input  logic       chk_hit,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  output logic [9:0] food_x,
  output logic [9:0] food_y,
  output logic       food_valid,
  output logic       food_pix,
  output logic [7:0] spawn_cnt
);

  // Query handshake: chk_req rises in CHECK and holds with chk_x/chk_y stable until
  // the cycle chk_ack is high; chk_hit is only meaningful in that same cycle.

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_SAMPLE = 3'd1,
    S_CHECK  = 3'd2,
    S_PLACE  = 3'd3,
    S_HOLD   = 3'd4
  } state_t;

  localparam logic [7:0]  MAX_RETRY_W = 8'(MAX_RETRY);
  localparam logic [10:0] FOOD_SIZE_W = 11'(FOOD_SIZE);
  localparam logic [9:0]  FOOD_X_RST  = 10'd320;
  localparam logic [9:0]  FOOD_Y_RST  = 10'd240;

  state_t     state;
  state_t     state_next;
  logic [7:0] retry_cnt;
  logic [9:0] cand_x;
  logic [9:0] cand_y;
  logic [10:0] x_end;
  logic [10:0] y_end;
  logic       in_x;
  logic       in_y;

  always_ff @(posedge clk_vga or posedge rst) begin
    if (rst) state <= S_INIT;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_INIT:   state_next = S_SAMPLE;
      S_SAMPLE: state_next = S_CHECK;
      S_CHECK: begin
        if (chk_ack) begin
          // A hit on the last allowed candidate still places it.
          if (chk_hit && (retry_cnt < MAX_RETRY_W)) state_next = S_SAMPLE;
          else                                      state_next = S_PLACE;
        end
      end
      S_PLACE:  state_next = S_HOLD;
      S_HOLD:   if (eat) state_next = S_SAMPLE;
      default:  state_next = S_INIT;
    endcase
  end

  always_comb begin
    chk_req    = 1'b0;
    food_valid = 1'b0;
    case (state)
      S_CHECK: chk_req    = 1'b1;
      S_HOLD:  food_valid = 1'b1;
      default: ;
    endcase
  end

  assign chk_x = cand_x;
  assign chk_y = cand_y;

  always_ff @(posedge clk_vga or posedge rst) begin
    if (rst) begin
      cand_x    <= '0;
      cand_y    <= '0;
      retry_cnt <= '0;
      food_x    <= FOOD_X_RST;
      food_y    <= FOOD_Y_RST;
      spawn_cnt <= '0;
    end else begin
      if (state == S_SAMPLE) begin
        cand_x    <= rand_x;
        cand_y    <= rand_y;
        retry_cnt <= retry_cnt + 8'd1;
      end
      if (state == S_PLACE) begin
        food_x    <= cand_x;
        food_y    <= cand_y;
        spawn_cnt <= spawn_cnt + 8'd1;
        retry_cnt <= '0;
      end
    end
  end

  // 11-bit end coordinates so a square near the right/bottom edge never wraps to 0.
  assign x_end = {1'b0, food_x} + FOOD_SIZE_W;
  assign y_end = {1'b0, food_y} + FOOD_SIZE_W;
  assign in_x  = (pix_x >= food_x) && ({1'b0, pix_x} < x_end);
  assign in_y  = (pix_y >= food_y) && ({1'b0, pix_y} < y_end);

  always_ff @(posedge clk_vga or posedge rst) begin
    if (rst) food_pix <= 1'b0;
    else     food_pix <= food_valid & in_x & in_y;
  end

endmodule

// File: tb/tb_food_ctrl.sv
// Directed bench for food_ctrl: spawn, retries, forced placement, pixel window, stall, reset.
`timescale 1ns/1ps
module tb_food_ctrl;

  logic       clk_vga = 1'b0;
  logic       rst;
  logic [9:0] rand_x, rand_y;
  logic       eat;
  logic       chk_req;
  logic [9:0] chk_x, chk_y;
  logic       chk_ack, chk_hit;
  logic [9:0] pix_x, pix_y;
  logic [9:0] food_x, food_y;
  logic       food_valid, food_pix;
  logic [7:0] spawn_cnt;

  int n_cmp = 0;
  int n_err = 0;

  food_ctrl #(.FOOD_SIZE(10), .MAX_RETRY(8)) dut (
    .clk_vga(clk_vga), .rst(rst), .rand_x(rand_x), .rand_y(rand_y), .eat(eat),
    .chk_req(chk_req), .chk_x(chk_x), .chk_y(chk_y), .chk_ack(chk_ack), .chk_hit(chk_hit),
    .pix_x(pix_x), .pix_y(pix_y), .food_x(food_x), .food_y(food_y),
    .food_valid(food_valid), .food_pix(food_pix), .spawn_cnt(spawn_cnt)
  );

  always #5 clk_vga = ~clk_vga;

  task automatic step();
    @(posedge clk_vga);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Bounded wait for an open query; an expired budget shows up as a failed check.
  task automatic wait_req(input string tag);
    int n = 0;
    while (chk_req !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    check(tag, 32'(chk_req), 1);
  endtask

  // Answer the open query, then move to the cycle after the ack edge.
  task automatic answer(input logic hit);
    chk_ack = 1'b1;
    chk_hit = hit;
    step();
    chk_ack = 1'b0;
    chk_hit = 1'b0;
  endtask

  task automatic pulse_eat();
    eat = 1'b1;
    step();
    eat = 1'b0;
  endtask

  task automatic pix_check(input string tag, input int px, input int py, input logic exp);
    pix_x = 10'(px);
    pix_y = 10'(py);
    step();
    check(tag, 32'(food_pix), 32'(exp));
  endtask

  initial begin
    rst = 1'b1; rand_x = 10'd120; rand_y = 10'd80; eat = 1'b0;
    chk_ack = 1'b0; chk_hit = 1'b0; pix_x = '0; pix_y = '0;

    // Reset values
    step(); step();
    check("rst_chk_req", 32'(chk_req), 0);
    check("rst_food_valid", 32'(food_valid), 0);
    check("rst_food_x", 32'(food_x), 320);
    check("rst_food_y", 32'(food_y), 240);
    check("rst_spawn", 32'(spawn_cnt), 0);
    check("rst_food_pix", 32'(food_pix), 0);
    check("rst_chk_x", 32'(chk_x), 0);

    // First spawn: INIT, SAMPLE, CHECK, PLACE, HOLD on cycle 5
    rst = 1'b0;
    step();
    check("c2_sample_req", 32'(chk_req), 0);
    step();
    check("c3_check_req", 32'(chk_req), 1);
    check("c3_chk_x", 32'(chk_x), 120);
    check("c3_chk_y", 32'(chk_y), 80);
    answer(1'b0);
    check("c4_place_req", 32'(chk_req), 0);
    check("c4_place_valid", 32'(food_valid), 0);
    step();
    check("c5_valid", 32'(food_valid), 1);
    check("c5_food_x", 32'(food_x), 120);
    check("c5_food_y", 32'(food_y), 80);
    check("c5_spawn", 32'(spawn_cnt), 1);

    // Acks and hits outside CHECK change nothing
    chk_ack = 1'b1; chk_hit = 1'b1;
    step(); step();
    chk_ack = 1'b0; chk_hit = 1'b0;
    check("stray_ack_valid", 32'(food_valid), 1);
    check("stray_ack_req", 32'(chk_req), 0);
    check("stray_ack_spawn", 32'(spawn_cnt), 1);

    // Two hits then a miss: three queries, the third candidate is placed
    rand_x = 10'd11; rand_y = 10'd12;
    pulse_eat();
    check("eat_valid_low", 32'(food_valid), 0);
    check("eat_food_x_kept", 32'(food_x), 120);
    wait_req("q1_req");
    check("q1_chk_x", 32'(chk_x), 11);
    rand_x = 10'd13; rand_y = 10'd14;
    answer(1'b1);
    check("q1_resample_req", 32'(chk_req), 0);
    wait_req("q2_req");
    check("q2_chk_y", 32'(chk_y), 14);
    rand_x = 10'd300; rand_y = 10'd200;
    answer(1'b1);
    wait_req("q3_req");
    check("q3_chk_x", 32'(chk_x), 300);
    answer(1'b0);
    check("q3_place_req", 32'(chk_req), 0);
    step();
    check("r2_valid", 32'(food_valid), 1);
    check("r2_food_x", 32'(food_x), 300);
    check("r2_food_y", 32'(food_y), 200);
    check("r2_spawn", 32'(spawn_cnt), 2);
    check("r2_retry", 32'(dut.retry_cnt), 0);

    // Hit forever: eight queries, then the eighth candidate is forced in
    pulse_eat();
    for (int i = 0; i < 8; i++) begin
      rand_x = 10'(100 + i * 10);
      rand_y = 10'(50 + i * 5);
      wait_req("mr_req");
      check("mr_chk_x", 32'(chk_x), 32'(100 + i * 10));
      answer(1'b1);
    end
    check("mr_no_ninth_req", 32'(chk_req), 0);
    check("mr_place_valid", 32'(food_valid), 0);
    step();
    check("mr_valid", 32'(food_valid), 1);
    check("mr_food_x", 32'(food_x), 170);
    check("mr_food_y", 32'(food_y), 85);
    check("mr_retry", 32'(dut.retry_cnt), 0);
    check("mr_spawn", 32'(spawn_cnt), 3);

    // Food at (610,450): pixel window with one-cycle lag
    rand_x = 10'd610; rand_y = 10'd450;
    pulse_eat();
    wait_req("pw_req");
    answer(1'b0);
    step();
    check("pw_food_x", 32'(food_x), 610);
    pix_check("pix_610", 610, 455, 1'b1);
    pix_check("pix_619", 619, 455, 1'b1);
    pix_check("pix_609", 609, 455, 1'b0);
    pix_check("pix_620", 620, 455, 1'b0);
    pix_check("pix_y449", 615, 449, 1'b0);
    pix_check("pix_y460", 615, 460, 1'b0);
    pix_check("pix_y450", 615, 450, 1'b1);
    pix_check("pix_y459", 615, 459, 1'b1);
    pix_x = 10'd0; pix_y = 10'd0;
    #2;
    check("pix_lag_hold", 32'(food_pix), 1);
    step();
    check("pix_lag_drop", 32'(food_pix), 0);

    // Food at the right edge: end sum must not wrap
    rand_x = 10'd1020; rand_y = 10'd100;
    pulse_eat();
    pix_x = 10'd1022; pix_y = 10'd105;
    step();
    check("respawn_pix_off", 32'(food_pix), 0);
    wait_req("edge_req");
    answer(1'b0);
    step();
    check("edge_spawn", 32'(spawn_cnt), 5);
    pix_check("edge_1022", 1022, 105, 1'b1);
    pix_check("edge_1023", 1023, 105, 1'b1);
    pix_check("edge_2", 2, 105, 1'b0);

    // Stalled query: 20 cycles without ack, eat and rand changes ignored
    rand_x = 10'd200; rand_y = 10'd100;
    pulse_eat();
    wait_req("st_req");
    for (int i = 0; i < 20; i++) begin
      rand_x = 10'($urandom_range(0, 1023));
      rand_y = 10'($urandom_range(0, 1023));
      eat = (i % 3 == 0);
      step();
      check("st_req_hold", 32'(chk_req), 1);
      check("st_chk_x", 32'(chk_x), 200);
      check("st_chk_y", 32'(chk_y), 100);
    end
    eat = 1'b0;
    check("st_spawn", 32'(spawn_cnt), 5);
    answer(1'b0);
    step();
    check("st_food_x", 32'(food_x), 200);
    check("st_spawn_after", 32'(spawn_cnt), 6);

    // Reset during an open query acts immediately
    rand_x = 10'd55; rand_y = 10'd44;
    pulse_eat();
    wait_req("rq_req");
    rst = 1'b1;
    #1;
    check("rq_req_drop", 32'(chk_req), 0);
    check("rq_valid", 32'(food_valid), 0);
    check("rq_spawn", 32'(spawn_cnt), 0);
    check("rq_food_x", 32'(food_x), 320);
    check("rq_food_y", 32'(food_y), 240);
    step();
    rand_x = 10'd77; rand_y = 10'd66;
    rst = 1'b0;
    step();
    check("rr_sample_req", 32'(chk_req), 0);
    step();
    check("rr_check_req", 32'(chk_req), 1);
    check("rr_chk_x", 32'(chk_x), 77);
    answer(1'b0);
    step();
    check("rr_valid", 32'(food_valid), 1);
    check("rr_food_y", 32'(food_y), 66);
    check("rr_spawn", 32'(spawn_cnt), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/food_ctrl.md
# food_ctrl

Food-placement controller for the VGA snake game. It sits directly downstream of the random point generator. On reset release or an eat event it latches a candidate coordinate from the generator and asks the snake body logic whether that point collides. It retries on collision, then holds the accepted position and drives a registered per-pixel food flag to the VGA colour mux.

## Interface

Parameters:
- FOOD_SIZE, 10: food square edge in pixels.
- MAX_RETRY, 8: maximum candidates checked per spawn, 1..255.

Ports:
- clk_vga  in  1  VGA pixel clock; all logic on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- rand_x  in  10  candidate x from the random point generator, pixels.
- rand_y  in  10  candidate y from the random point generator, pixels.
- eat  in  1  single-cycle pulse: snake head hit the current food.
- chk_req  out  1  collision query request.
- chk_x  out  10  queried x; stable while chk_req is high.
- chk_y  out  10  queried y; stable while chk_req is high.
- chk_ack  in  1  query answered this cycle.
- chk_hit  in  1  candidate overlaps the snake; valid only when chk_ack is high.
- pix_x  in  10  current VGA scan x.
- pix_y  in  10  current VGA scan y.
- food_x  out  10  accepted food x (top-left corner).
- food_y  out  10  accepted food y (top-left corner).
- food_valid  out  1  food position is live.
- food_pix  out  1  current scan pixel lies inside the food square.
- spawn_cnt  out  8  count of placed foods; wraps 255 to 0.

## Operation

- States:
  - INIT: reset state. Unconditionally moves to SAMPLE on the next cycle, which lets the generator settle.
  - SAMPLE: cand_x/cand_y <= rand_x/rand_y; retry_cnt <= retry_cnt+1. Next state is CHECK.
  - CHECK: chk_req=1 and chk_x/chk_y = cand. Waits for chk_ack.
    - On ack with chk_hit=1 and retry_cnt<MAX_RETRY: go to SAMPLE.
    - On ack with chk_hit=0, or retry_cnt==MAX_RETRY: go to PLACE. Placement is forced after MAX_RETRY candidates.
  - PLACE: food_x/food_y <= cand; spawn_cnt <= spawn_cnt+1; retry_cnt <= 0. Next state is HOLD.
  - HOLD: food_valid=1. eat=1 moves to SAMPLE.
- chk_req and food_valid are decoded from the registered state and are glitch-free.
- eat is ignored in every state except HOLD; there is no queueing.
- Any chk_ack seen outside CHECK is ignored.
- food_pix is registered and equals food_valid & (food_x ≤ pix_x < food_x+FOOD_SIZE) & (food_y ≤ pix_y < food_y+FOOD_SIZE).
  - Sums are computed in 11 bits, so food_x=1020 does not wrap to match low pix_x.
- Reset values:
  - state INIT, retry_cnt 0, spawn_cnt 0.
  - food_x 320, food_y 240.
  - cand 0, food_valid 0, food_pix 0, chk_req 0.
- Reset mid-operation, including during an open query: all state returns to reset values immediately and chk_req drops asynchronously.

## Timing

- Spawn after reset release with an immediate ack:
  - Cycle 1 INIT, 2 SAMPLE, 3 CHECK (chk_req high), 4 PLACE.
  - food_valid is high from cycle 5.
- Eat to new food with a no-hit ack in the same cycle as chk_req: eat sampled at edge n; food_valid low from n+1 through n+3; high again at n+4.
  - Latency is 4 cycles plus ack wait cycles, plus 2 cycles per rejected candidate.
- food_x/food_y change only at the PLACE→HOLD edge. During respawn they keep the old value, but food_pix is 0 because food_valid is low.
- food_pix lags pix_x/pix_y by exactly 1 cycle.

## Test plan

- Reset release, rand=(120,80), chk_ack=1 and chk_hit=0 on the first chk_req:
  - chk_x/chk_y=120/80; food_x/food_y=120/80.
  - food_valid rises on cycle 5; spawn_cnt=1.
- In HOLD, pulse eat with rand=(300,200), and hit on the first two queries, no hit on the third:
  - exactly 3 chk_req windows; food=(300,200) sampled on the third SAMPLE; spawn_cnt increments by 1.
- MAX_RETRY=8 with chk_hit=1 forever:
  - exactly 8 queries, then forced PLACE of the 8th candidate; food_valid=1; retry_cnt back to 0.
- Food at (610,450), scan pix_y=455:
  - food_pix=1 one cycle after pix_x=610..619; 0 at 609 and 620.
  - food_pix=0 at pix_y=449 and 460.
- Hold chk_ack low for 20 cycles in CHECK:
  - chk_req and chk_x/chk_y stay stable; eat pulses are ignored; spawn_cnt is unchanged.
- Assert rst during CHECK:
  - chk_req, food_valid and spawn_cnt are 0 the same cycle; food=(320,240).
  - After release the INIT→SAMPLE sequence restarts.
